stream_mux_rr: RTL and testbench

//  Registered N-channel, W-bit stream multiplexer with valid/ready handshakes.

---
 rtl/stream_mux_rr.sv | 142 ++++++++++++++
 tb/tb_stream_mux_rr.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered NUM_CH:1 stream multiplexer with valid/ready handshakes.
// The arbiter runs in one of two modes. In fixed mode it forwards the channel named
// by sel. In round-robin mode it grants the first valid channel after the last
// channel that transferred. One output register decouples downstream timing.

// Per-channel ready slice: asserts when this channel owns the current grant.
module stream_mux_rr_ch #(
    parameter int CH_W = 2,
    parameter int IDX  = 0
) (
    input  logic [CH_W-1:0] gnt,
    input  logic            grant_en,
    output logic            ready
);
    localparam logic [CH_W-1:0] MY_IDX = CH_W'(IDX);

    assign ready = grant_en && (gnt == MY_IDX);
endmodule

module stream_mux_rr #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [CH_W-1:0]         sel,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    // Output stage and arbitration state
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [CH_W-1:0]   out_ch_q,    out_ch_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;

    // Arbitration signals
    logic [NUM_CH-1:0][WIDTH-1:0] ch_data;
    logic              load;
    logic              sel_in_range;
    logic [CH_W-1:0]   rr_gnt;
    logic              rr_found;
    logic [CH_W-1:0]   gnt;
    logic              gnt_vld;
    logic              grant_en;

    assign ch_data = in_data;

    // The output register may take a new word when it is empty or being drained.
    assign load = !out_valid_q || out_ready;

    // Round-robin scan: first valid channel at last_grant+1, +2, ... modulo NUM_CH.
    always_comb begin
        logic [CH_W-1:0] idx;
        rr_gnt   = '0;
        rr_found = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = CH_W'((int'(last_grant_q) + k) % NUM_CH);
            if (!rr_found && in_valid[idx]) begin
                rr_found = 1'b1;
                rr_gnt   = idx;
            end
        end
    end

    // Mode select: fixed channel from sel, or the round-robin winner.
    always_comb begin
        sel_in_range = (int'(sel) < NUM_CH);
        gnt          = '0;
        gnt_vld      = 1'b0;
        if (mode) begin
            gnt     = rr_gnt;
            gnt_vld = rr_found;
        end else begin
            gnt     = sel;
            gnt_vld = sel_in_range && in_valid[sel];
        end
    end

    // Readies are held low during reset because reset discards any transfer.
    assign grant_en = load && gnt_vld && !rst;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            stream_mux_rr_ch #(
                .CH_W (CH_W),
                .IDX  (gi)
            ) u_ch (
                .gnt      (gnt),
                .grant_en (grant_en),
                .ready    (in_ready[gi])
            );
        end
    endgenerate

    // Next-state for the output register; data and channel hold when nothing loads.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        last_grant_d = last_grant_q;
        if (load) begin
            out_valid_d = gnt_vld;
            if (gnt_vld) begin
                out_data_d   = ch_data[gnt];
                out_ch_d     = gnt;
                last_grant_d = gnt;
            end
        end
    end

    // State registers; reset leaves channel 0 first in round-robin order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            last_grant_q <= LAST_CH;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (NUM_CH=4, WIDTH=8). Inputs change 1 ns after a
// rising edge; in_ready is sampled 1 ns later and registered outputs right after.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    stream_mux_rr #(.NUM_CH(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
        in_data = {8'h33, 8'h22, 8'h11, 8'h00};
        step();
        step();
        #1;
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (out_data !== 8'h00) $display("FAIL reset_out_data got %h want 00", out_data);
        else pass_cnt++;
        chk_cnt++;
        if (out_ch !== 2'd0) $display("FAIL reset_out_ch got %0d want 0", out_ch);
        else pass_cnt++;
        chk_cnt++;
        if (in_ready !== 4'b0000) $display("FAIL reset_in_ready got %b want 0000", in_ready);
        else pass_cnt++;
        rst = 1'b0; in_valid = 4'h0;
        step();
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {8'h33, 8'hA5, 8'h11, 8'h00};
        #1;
        chk_cnt++;
        if (in_ready !== 4'b0100) $display("FAIL fixed_in_ready got %b want 0100", in_ready);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2)
            $display("FAIL fixed_out got v=%b d=%h ch=%0d want v=1 d=a5 ch=2",
                     out_valid, out_data, out_ch);
        else pass_cnt++;
        in_valid = 4'b0000;
        step();
        chk_cnt++;
        if (out_valid !== 1'b0 || out_data !== 8'hA5 || out_ch !== 2'd2)
            $display("FAIL fixed_idle_hold got v=%b d=%h ch=%0d want v=0 d=a5 ch=2",
                     out_valid, out_data, out_ch);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        logic [1:0] exp_ch;
        // Reset again so channel 0 has first priority.
        rst = 1'b1; in_valid = 4'h0;
        step();
        rst = 1'b0;
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int k = 0; k < 8; k++) begin
            exp_ch  = 2'(k % 4);
            exp_rdy = 4'b0001 << exp_ch;
            #1;
            chk_cnt++;
            if (in_ready !== exp_rdy)
                $display("FAIL rr_in_ready[%0d] got %b want %b", k, in_ready, exp_rdy);
            else pass_cnt++;
            step();
            chk_cnt++;
            if (out_valid !== 1'b1 || out_ch !== exp_ch || out_data !== (8'h10 + 8'(exp_ch)))
                $display("FAIL rr_out[%0d] got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                         k, out_valid, out_ch, out_data, exp_ch, 8'h10 + 8'(exp_ch));
            else pass_cnt++;
        end
    endtask

    task automatic test_sparse_wrap();
        logic [1:0] exp_seq [3];
        exp_seq[0] = 2'd1; exp_seq[1] = 2'd3; exp_seq[2] = 2'd1;
        // last grant is channel 3 after the round-robin test, so the scan wraps.
        mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
        in_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_cnt++;
            if (in_ready !== (4'b0001 << exp_seq[k]))
                $display("FAIL sparse_in_ready[%0d] got %b want %b",
                         k, in_ready, 4'b0001 << exp_seq[k]);
            else pass_cnt++;
            step();
            chk_cnt++;
            if (out_valid !== 1'b1 || out_ch !== exp_seq[k])
                $display("FAIL sparse_out[%0d] got v=%b ch=%0d want v=1 ch=%0d",
                         k, out_valid, out_ch, exp_seq[k]);
            else pass_cnt++;
        end
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_backpressure();
        // Load 0x3C from channel 0 via fixed select.
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
        in_data = {8'h77, 8'h66, 8'h5A, 8'h3C};
        step();
        chk_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C)
            $display("FAIL bp_load got v=%b d=%h want v=1 d=3c", out_valid, out_data);
        else pass_cnt++;
        // Stall for 3 cycles; last grant is 0 so round-robin would pick channel 1.
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_cnt++;
            if (in_ready !== 4'b0000)
                $display("FAIL bp_in_ready[%0d] got %b want 0000", k, in_ready);
            else pass_cnt++;
            step();
            chk_cnt++;
            if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 2'd0)
                $display("FAIL bp_hold[%0d] got v=%b d=%h ch=%0d want v=1 d=3c ch=0",
                         k, out_valid, out_data, out_ch);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
        chk_cnt++;
        if (in_ready !== 4'b0010)
            $display("FAIL bp_release_ready got %b want 0010", in_ready);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || out_ch !== 2'd1)
            $display("FAIL bp_release_out got v=%b d=%h ch=%0d want v=1 d=5a ch=1",
                     out_valid, out_data, out_ch);
        else pass_cnt++;
    endtask

    task automatic test_edge_cases();
        // Fixed select on a channel that is not valid drains the output.
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1011; out_ready = 1'b1;
        #1;
        chk_cnt++;
        if (in_ready !== 4'b0000)
            $display("FAIL edge_sel_invalid_ready got %b want 0000", in_ready);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (out_valid !== 1'b0 || out_data !== 8'h5A)
            $display("FAIL edge_sel_invalid_out got v=%b d=%h want v=0 d=5a",
                     out_valid, out_data);
        else pass_cnt++;
        // Load a word, stall it, then reset: the stalled word is dropped.
        sel = 2'd3; in_valid = 4'b1000;
        in_data = {8'hC3, 8'h66, 8'h5A, 8'h3C};
        step();
        chk_cnt++;
        if (out_valid !== 1'b1 || out_data !== 8'hC3 || out_ch !== 2'd3)
            $display("FAIL edge_preload got v=%b d=%h ch=%0d want v=1 d=c3 ch=3",
                     out_valid, out_data, out_ch);
        else pass_cnt++;
        out_ready = 1'b0; rst = 1'b1;
        step();
        chk_cnt++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0)
            $display("FAIL edge_rst_stall got v=%b d=%h ch=%0d want v=0 d=00 ch=0",
                     out_valid, out_data, out_ch);
        else pass_cnt++;
        rst = 1'b0; in_valid = 4'b0000; out_ready = 1'b1;
        step();
        chk_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL edge_dropped got v=%b want 0", out_valid);
        else pass_cnt++;
        // After reset, round-robin starts at channel 0.
        mode = 1'b1; in_valid = 4'b1111;
        #1;
        chk_cnt++;
        if (in_ready !== 4'b0001)
            $display("FAIL edge_rr_restart got %b want 0001", in_ready);
        else pass_cnt++;
        step();
        in_valid = 4'b0000;
        step();
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'h0;
        in_data = 32'h0; out_ready = 1'b1;
        test_reset();
        test_fixed();
        test_round_robin();
        test_sparse_wrap();
        test_backpressure();
        test_edge_cases();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
